div_sched: RTL and testbench
============================

# div_sched

Round-robin scheduler that shares one fixed-latency pipelined divider between two requesters. It arbitrates requests, issues one division per cycle into the divider pipeline, and tracks each operation's owner and divide-by-zero status in a tag pipe aligned to the divider latency. It collects results into an output FIFO under credit control, because the divider pipeline cannot stall. It sits between requesting blocks and the divider cell chain.

## Interface
- N, 6, dividend / quotient width
- M, 4, divisor / remainder width
- LAT, 5, divider pipeline latency in cycles, issue to result (≥1)
- FIFO_DEPTH, 8, result FIFO entries; must be ≥ LAT+2 for full throughput, power of two

- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept
- req_dividend  in  2×N  packed operands, requester i at [i*N +: N]
- req_divisor  in  2×M  packed operands, requester i at [i*M +: M]
- div_vld  out  1  issue strobe to divider pipeline
- div_dividend  out  N  operand to divider
- div_divisor  out  M  operand to divider
- div_quotient  in  N  divider result, valid LAT cycles after div_vld
- div_remainder  in  M  divider result
- res_valid  out  1  result available
- res_ready  in  1  consumer accept
- res_id  out  1  owning requester
- res_quotient  out  N  quotient
- res_remainder  out  M  remainder
- res_dz  out  1  divide-by-zero flag

## Operation
- Credit counter `cnt` (0..FIFO_DEPTH) counts in-flight operations plus FIFO entries.
- Transitions:
  - +1 on accept.
  - −1 on pop (res_valid & res_ready).
  - Both in the same cycle: unchanged.
- Grant is possible only when cnt < FIFO_DEPTH. There is no same-cycle pop bypass.
- Arbiter:
  - A pointer `prio` (reset 0) selects the preferred requester.
  - If only one requester is valid, it wins.
  - If both are valid, `prio` wins.
  - After any grant, prio ← ~granted id.
  - req_ready[i] is high only for the granted requester. At most one bit is set.
  - req_ready is combinational from req_valid, prio and cnt.
- Issue stage: on accept, register the operands, id and dz (divisor == 0) into the issue regs. div_vld pulses for exactly one cycle per accept.
- Tag pipe: a LAT-deep shift register of {vld, id, dz}. It is loaded from the issue stage and advances every cycle.
- When the tag pipe output is valid, write {id, dz, quotient, remainder} into the FIFO.
- The FIFO never overflows, by the credit rule. A write to a full FIFO is an assertion failure.
- res_* reflect the FIFO head. Output order equals issue order.

## Timing
- Accept at the edge ending cycle t.
- div_vld is high in cycle t+1.
- Divider result is valid in cycle t+1+LAT and captured at the end of that cycle.
- res_valid is high from cycle t+2+LAT. Minimum request-to-result latency is LAT+2.
- Sustained throughput: 1 op/cycle while res_ready is held high.
- Reset values: req_ready=0, div_vld=0, div_dividend=0, div_divisor=0, res_valid=0, res_id=0, res_quotient=0, res_remainder=0, res_dz=0, cnt=0, prio=0, all tag vld=0, FIFO empty.
- Reset mid-operation:
  - All in-flight and queued results are discarded.
  - Divider pipeline contents are ignored because the tag vld bits are cleared.
  - The first request after rstn rises may be accepted in that same cycle.
- res_* hold stable while res_valid & !res_ready.

## Configuration
- `DIV_SCHED_DZ_CHECK_EN` defined:
  - dz = (divisor == 0) is carried in the tag pipe.
  - On a dz result, res_quotient is forced to all ones, res_remainder to dividend[M-1:0], and res_dz=1.
  - This requires the dividend's low M bits to travel in the tag pipe.
- Not defined:
  - The tag pipe carries no dz or dividend bits.
  - res_dz is tied to 0.
  - Raw divider outputs pass through unchanged.

## Structure
- Package `div_pkg`: result record typedef {id, dz, quotient, remainder}, and the requester-count constant 2.
- Sub-module `div_res_fifo`: synchronous FIFO with parameterized width and FIFO_DEPTH, providing full/empty and a first-word-fall-through head.
- The arbiter, credit counter and tag pipe stay in div_sched.

## Test plan
- Single op: req 0 with 45/7, LAT=5 → res_valid at cycle t+7, quotient 6, remainder 3, id 0, dz 0.
- Both requesters valid continuously, res_ready=1 → grants alternate 0,1,0,1; one result per cycle; ids alternate in issue order.
- res_ready=0 with requester 1 valid → exactly FIFO_DEPTH accepts, then req_ready=0. One pop → exactly one further accept, no earlier.
- Divisor 0, dividend 13, with the macro defined → quotient 63, remainder 13, dz 1. Without the macro → dz 0 and raw divider value.
- rstn low for one cycle with 3 ops in flight → no res_valid afterwards, cnt=0. A new request completes normally at LAT+2.
- Accept and pop in the same cycle at cnt=FIFO_DEPTH-1 → cnt unchanged, no overflow.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the divider scheduler: requester count and result record.
// Default operand widths used by div_sched and its result FIFO.
package div_pkg;

  localparam int REQ_N = 2;
  localparam int DIV_N = 6;
  localparam int DIV_M = 4;

  typedef struct packed {
    logic             id;
    logic             dz;
    logic [DIV_N-1:0] quotient;
    logic [DIV_M-1:0] remainder;
  } div_res_t;

endpackage

// File: rtl/div_res_fifo.sv
// Result FIFO for div_sched: synchronous, first-word-fall-through head.
// Head reads as zero while empty so the result outputs idle at zero.
module div_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic [W-1:0] mem [DEPTH];
  logic         wr_ok;
  logic         rd_ok;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) wp <= wp + (AW+1)'(1);
      if (rd_ok) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one pipelined divider between two requesters.
// DIV_SCHED_DZ_CHECK_EN: carry divide-by-zero status and patch dz results.
module div_sched
  import div_pkg::*;
#(
  parameter int N          = DIV_N,
  parameter int M          = DIV_M,
  parameter int LAT        = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [REQ_N-1:0]   req_valid,
  output logic [REQ_N-1:0]   req_ready,
  input  logic [REQ_N*N-1:0] req_dividend,
  input  logic [REQ_N*M-1:0] req_divisor,
  output logic               div_vld,
  output logic [N-1:0]       div_dividend,
  output logic [M-1:0]       div_divisor,
  input  logic [N-1:0]       div_quotient,
  input  logic [M-1:0]       div_remainder,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [N-1:0]       res_quotient,
  output logic [M-1:0]       res_remainder,
  output logic               res_dz
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]  cnt;
  logic           prio;
  logic           gid;
  logic           acc;
  logic           pop;
  logic [N-1:0]   sel_dvd;
  logic [M-1:0]   sel_dvs;
  logic           iss_id;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;
`ifdef DIV_SCHED_DZ_CHECK_EN
  logic           iss_dz;
  logic [M-1:0]   iss_lo;
  logic [LAT-1:0] tag_dz;
  logic [M-1:0]   tag_lo [LAT];
`endif
  div_res_t       wr_res;
  div_res_t       rd_res;
  logic           fifo_full;
  logic           fifo_empty;

  // Credit gate: cnt covers in-flight ops plus queued results.
  always_comb begin
    gid       = (&req_valid) ? prio : req_valid[1];
    acc       = rstn & (|req_valid) & (cnt < CW'(FIFO_DEPTH));
    req_ready = '0;
    if (acc) req_ready[gid] = 1'b1;
    sel_dvd   = gid ? req_dividend[N +: N] : req_dividend[0 +: N];
    sel_dvs   = gid ? req_divisor[M +: M] : req_divisor[0 +: M];
  end

  assign pop = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt          <= '0;
      prio         <= 1'b0;
      div_vld      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      iss_id       <= 1'b0;
      tag_vld      <= '0;
      tag_id       <= '0;
`ifdef DIV_SCHED_DZ_CHECK_EN
      iss_dz       <= 1'b0;
      iss_lo       <= '0;
      tag_dz       <= '0;
      for (int k = 0; k < LAT; k++) tag_lo[k] <= '0;
`endif
    end else begin
      div_vld <= acc;
      if (acc) begin
        prio         <= ~gid;
        div_dividend <= sel_dvd;
        div_divisor  <= sel_dvs;
        iss_id       <= gid;
`ifdef DIV_SCHED_DZ_CHECK_EN
        iss_dz       <= (sel_dvs == '0);
        iss_lo       <= sel_dvd[M-1:0];
`endif
      end
      if (acc && !pop) cnt <= cnt + CW'(1);
      else if (!acc && pop) cnt <= cnt - CW'(1);
      // Tag pipe mirrors the divider so each result finds its owner.
      tag_vld[0] <= div_vld;
      tag_id[0]  <= iss_id;
`ifdef DIV_SCHED_DZ_CHECK_EN
      tag_dz[0]  <= iss_dz;
      tag_lo[0]  <= iss_lo;
`endif
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
`ifdef DIV_SCHED_DZ_CHECK_EN
        tag_dz[k]  <= tag_dz[k-1];
        tag_lo[k]  <= tag_lo[k-1];
`endif
      end
    end
  end

  always_comb begin
    wr_res    = '0;
    wr_res.id = tag_id[LAT-1];
`ifdef DIV_SCHED_DZ_CHECK_EN
    wr_res.dz        = tag_dz[LAT-1];
    wr_res.quotient  = tag_dz[LAT-1] ? '1 : div_quotient;
    wr_res.remainder = tag_dz[LAT-1] ? tag_lo[LAT-1]
                                     : div_remainder;
`else
    wr_res.quotient  = div_quotient;
    wr_res.remainder = div_remainder;
`endif
  end

  always_ff @(posedge clk) begin
    if (rstn && tag_vld[LAT-1]) assert (!fifo_full);
  end

  div_res_fifo #(
    .W     ($bits(div_res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (tag_vld[LAT-1]),
    .wr_data (wr_res),
    .rd_en   (res_ready),
    .rd_data (rd_res),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign res_valid     = ~fifo_empty;
  assign res_id        = rd_res.id;
  assign res_dz        = rd_res.dz;
  assign res_quotient  = rd_res.quotient;
  assign res_remainder = rd_res.remainder;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural LAT-stage divider.
// Expected values are hand-computed per step.
module tb_div_sched;

  localparam int N   = 6;
  localparam int M   = 4;
  localparam int LAT = 5;
  localparam int FD  = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_dividend;
  logic [2*M-1:0] req_divisor;
  logic           div_vld;
  logic [N-1:0]   div_dividend;
  logic [M-1:0]   div_divisor;
  logic [N-1:0]   div_quotient;
  logic [M-1:0]   div_remainder;
  logic           res_valid;
  logic           res_ready;
  logic           res_id;
  logic [N-1:0]   res_quotient;
  logic [M-1:0]   res_remainder;
  logic           res_dz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_sched #(.N(N), .M(M), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .div_vld       (div_vld),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_id        (res_id),
    .res_quotient  (res_quotient),
    .res_remainder (res_remainder),
    .res_dz        (res_dz)
  );

  // Divider model: zero divisor yields a recognisable raw value 2A/5.
  logic [N-1:0] pq [LAT];
  logic [M-1:0] pr [LAT];

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      pq[k] <= pq[k-1];
      pr[k] <= pr[k-1];
    end
    if (div_divisor == '0) begin
      pq[0] <= 6'h2A;
      pr[0] <= 4'h5;
    end else begin
      pq[0] <= N'(div_dividend / div_divisor);
      pr[0] <= M'(div_dividend % div_divisor);
    end
  end

  assign div_quotient  = pq[LAT-1];
  assign div_remainder = pr[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int acc_n;
  int pop_n;
  int wait_n;
  logic [5:0] exp_ids;

  initial begin
    rstn         = 1'b0;
    req_valid    = 2'b11;
    req_dividend = '0;
    req_divisor  = '0;
    res_ready    = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_div_vld", div_vld, 1'b0);
    chk("rst_div_dvd", div_dividend, 0);
    chk("rst_div_dvs", div_divisor, 0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_res_q", res_quotient, 0);
    chk("rst_res_r", res_remainder, 0);
    chk("rst_res_dz", res_dz, 1'b0);
    chk("rst_cnt", dut.cnt, 0);

    // Single op 45/7 from requester 0.
    rstn      = 1'b1;
    req_valid = 2'b01;
    req_dividend[0 +: N] = 6'd45;
    req_divisor[0 +: M]  = 4'd7;
    #1;
    chk("one_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("one_div_vld", div_vld, 1'b1);
    chk("one_div_dvd", div_dividend, 45);
    chk("one_div_dvs", div_divisor, 7);
    step();
    chk("one_div_vld_pulse", div_vld, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("one_early", res_valid, 1'b0);
      step();
    end
    chk("one_early_last", res_valid, 1'b0);
    step();
    chk("one_valid", res_valid, 1'b1);
    chk("one_q", res_quotient, 6);
    chk("one_r", res_remainder, 3);
    chk("one_id", res_id, 1'b0);
    chk("one_dz", res_dz, 1'b0);
    step();
    chk("hold_valid", res_valid, 1'b1);
    chk("hold_q", res_quotient, 6);
    chk("hold_r", res_remainder, 3);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("one_popped", res_valid, 1'b0);
    chk("one_cnt", dut.cnt, 0);

    // Both requesters; prio is 1 after the grant to 0.
    req_valid = 2'b11;
    req_dividend = {6'd63, 6'd20};
    req_divisor  = {4'd8, 4'd3};
    res_ready = 1'b1;
    exp_ids = 6'b010101;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("alt_grant", req_ready, exp_ids[i] ? 2'b10 : 2'b01);
      step();
    end
    req_valid = 2'b00;
    wait_n = 0;
    while (!res_valid && wait_n < 20) begin
      step();
      wait_n++;
    end
    chk("alt_timeout", wait_n < 20, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("alt_valid", res_valid, 1'b1);
      chk("alt_id", res_id, exp_ids[i]);
      chk("alt_q", res_quotient, exp_ids[i] ? 7 : 6);
      chk("alt_r", res_remainder, exp_ids[i] ? 7 : 2);
      step();
    end
    chk("alt_empty", res_valid, 1'b0);
    res_ready = 1'b0;

    // Backpressure: exactly FD credits, then one per pop.
    req_valid = 2'b10;
    req_dividend[N +: N] = 6'd50;
    req_divisor[M +: M]  = 4'd5;
    #1;
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready == 2'b10) acc_n++;
      step();
    end
    chk("bp_accepts", acc_n, FD);
    chk("bp_ready_low", req_ready, 2'b00);
    chk("bp_cnt_full", dut.cnt, FD);
    for (int i = 0; i < 6; i++) step();
    chk("bp_res_valid", res_valid, 1'b1);
    chk("bp_id", res_id, 1'b1);
    chk("bp_q", res_quotient, 10);
    chk("bp_r", res_remainder, 0);
    chk("bp_still_low", req_ready, 2'b00);
    res_ready = 1'b1;
    #1;
    chk("bp_no_bypass", req_ready, 2'b00);
    step();
    res_ready = 1'b0;
    #1;
    chk("bp_one_credit", req_ready, 2'b10);
    step();
    chk("bp_refull", req_ready, 2'b00);
    chk("bp_cnt_refull", dut.cnt, FD);
    res_ready = 1'b1;
    step();
    #1;
    chk("same_ready", req_ready, 2'b10);
    chk("same_cnt_pre", dut.cnt, FD - 1);
    step();
    chk("same_cnt_post", dut.cnt, FD - 1);
    req_valid = 2'b00;
    pop_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) pop_n++;
      step();
    end
    res_ready = 1'b0;
    chk("bp_drain", pop_n, FD - 1);
    chk("bp_cnt_zero", dut.cnt, 0);

    // Divide by zero from requester 0: 13/0.
    req_valid = 2'b01;
    req_dividend[0 +: N] = 6'd13;
    req_divisor[0 +: M]  = 4'd0;
    #1;
    chk("dz_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < LAT + 1; i++) step();
    chk("dz_valid", res_valid, 1'b1);
`ifdef DIV_SCHED_DZ_CHECK_EN
    chk("dz_q", res_quotient, 63);
    chk("dz_r", res_remainder, 13);
    chk("dz_flag", res_dz, 1'b1);
`else
    chk("dz_q", res_quotient, 6'h2A);
    chk("dz_r", res_remainder, 4'h5);
    chk("dz_flag", res_dz, 1'b0);
`endif
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset with three ops in flight, then a fresh op on rstn rise.
    req_valid = 2'b11;
    req_dividend = {6'd63, 6'd20};
    req_divisor  = {4'd8, 4'd3};
    step();
    step();
    step();
    req_valid = 2'b00;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("mid_cnt", dut.cnt, 0);
    chk("mid_res_valid", res_valid, 1'b0);
    req_valid = 2'b01;
    req_dividend[0 +: N] = 6'd45;
    req_divisor[0 +: M]  = 4'd7;
    #1;
    chk("mid_first_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < LAT + 1; i++) begin
      chk("mid_no_stale", res_valid, 1'b0);
      step();
    end
    chk("mid_valid", res_valid, 1'b1);
    chk("mid_q", res_quotient, 6);
    chk("mid_r", res_remainder, 3);
    chk("mid_id", res_id, 1'b0);
    res_ready = 1'b1;
    step();
    chk("mid_empty", res_valid, 1'b0);
    chk("mid_cnt_end", dut.cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
